mask_share_codec: RTL and testbench
===================================

Name: mask_share_codec

Overview:
- Plain-domain front/back end for our first-order, two-share Boolean-masked combinational cores, such as the masked thermostat controller.
- Encode side: accepts a plain input word and draws a fresh mask plus gadget randomness from the RNG. It drives registered shares sh0 = x^m and sh1 = m into the core.
- Decode side: after a fixed settle time, registers both output shares in separate flops, then recombines them into a plain result with a valid/ready handshake.
- Shares are never XORed combinationally before the share flops.

Parameters:
- IN_W, 4: plain input width. Bit map: [0] too_cold, [1] too_hot, [2] mode, [3] fan_on.
- OUT_W, 3: plain output width. Bit map: [0] heater, [1] aircon, [2] fan.
- RND_W, 4: gadget randomness bits per evaluation (r0..r3).
- CORE_LAT, 1: settle cycles allowed for the masked core. Must be >=1.
- RND_TIMEOUT, 16: RNG wait cycles before rnd_err is flagged. Must be >=1.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- in_valid, in, 1: plain input valid.
- in_ready, out, 1: high only in IDLE.
- in_data, in, IN_W: plain input word.
- rnd_valid, in, 1: RNG word valid.
- rnd_ready, out, 1: high only in RND.
- rnd_data, in, IN_W+RND_W: [IN_W-1:0] is the mask m; the upper RND_W bits are the gadget randomness r.
- sh0_out, out, IN_W: share 0 to the core.
- sh1_out, out, IN_W: share 1 to the core.
- gad_rnd, out, RND_W: gadget randomness to the core.
- sh0_in, in, OUT_W: share 0 from the core.
- sh1_in, in, OUT_W: share 1 from the core.
- out_valid, out, 1: plain result valid.
- out_ready, in, 1: downstream ready.
- out_data, out, OUT_W: plain result.
- busy, out, 1: state != IDLE.
- rnd_err, out, 1: sticky RNG-starvation flag.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All registered outputs and internal regs are 0: sh0_out, sh1_out, gad_rnd, out_data, out_valid, rnd_err, counters. Combinational in_ready=1 while in reset and in IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid at edge: plain_q<=in_data, go to RND, wait counter<=0.
- RND:
  - rnd_ready=1.
  - On rnd_valid at edge:
    - sh0_out<=plain_q^m; sh1_out<=m; gad_rnd<=r.
    - plain_q<=0, so the plain value is cleared as soon as it is masked.
    - settle counter<=CORE_LAT-1; go to SETTLE.
  - Otherwise the wait counter increments, saturating at RND_TIMEOUT. When it reaches RND_TIMEOUT, rnd_err<=1.
  - rnd_err stays set until reset. The FSM keeps waiting; there is no abort.
- SETTLE:
  - Shares are held stable.
  - If counter==0: q0<=sh0_in, q1<=sh1_in, go to UNMASK. Otherwise decrement.
- UNMASK (one cycle):
  - out_data<=q0^q1; out_valid<=1.
  - sh0_out, sh1_out, gad_rnd, q0, q1 <= 0.
  - Go to OUT.
- OUT:
  - out_data stays stable while out_valid=1.
  - On out_ready at edge: out_valid<=0, out_data<=0, go to IDLE.
- Latency, with in accepted at edge E0 and rnd_valid held high:
  - Shares are visible after E1.
  - Core outputs are captured at E(1+CORE_LAT).
  - out_valid=1 after E(2+CORE_LAT).
  - Minimum period is CORE_LAT+4 cycles per transaction. There is no overlap.
- Mask m=0 is legal: sh1_out=0, and the result is still correct.
- in_valid outside IDLE and rnd_valid outside RND are ignored; the data is not consumed.
- rnd_data is consumed exactly once per transaction. It is never reused.
- Reset mid-transaction: all shares and the result clear immediately. No out_valid follows. in_ready=1 after release.

Decomposition:
- Shared package mask_codec_pkg holds:
  - state enum {IDLE, RND, SETTLE, UNMASK, OUT};
  - the bit-index constants for the in_data and out_data maps;
  - default widths.
- No sub-module; the block is a single FSM plus datapath registers.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 with random inputs driven.
  - Response: all outputs 0, in_ready=1. After release: busy=0, rnd_err=0.
- Encode/decode, CORE_LAT=1:
  - Stimulus: in_data=4'b1010, m=4'b0110, r=4'b1001.
  - Response after E1: sh0_out=4'b1100, sh1_out=4'b0110, gad_rnd=4'b1001.
  - Stimulus: drive sh0_in=3'b101, sh1_in=3'b011.
  - Response: out_data=3'b110, out_valid=1 after E3; shares read 0 after E3.
- With the masked thermostat core in the loop:
  - mode=1, too_cold=1, fan_on=0 -> out_data=3'b101.
  - mode=0, too_hot=1 -> 3'b110.
  - All-zero input -> 3'b000.
  - Each case is repeated with 50 random masks and the result must be identical.
- RNG starvation, RND_TIMEOUT=16:
  - Stimulus: hold rnd_valid low for 20 cycles.
  - Response: rnd_err rises after 16 RND cycles and stays high. The transaction then completes correctly once rnd_valid rises.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles.
  - Response: out_data stable, out_valid=1, in_ready=0. Stimulus: out_ready=1. Response: IDLE on the next cycle, out_data=0.
- Reset during SETTLE:
  - Response: sh0_out and sh1_out drop to 0 asynchronously. No out_valid follows. A new transaction after release produces the correct result.

Source files
------------

// File: rtl/mask_codec_pkg.sv
// Shared types and constants for the two-share masking codec.
// State encoding, plain-word bit maps and default widths.
package mask_codec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RND,
        SETTLE,
        UNMASK,
        OUT
    } state_e;

    localparam int DEF_IN_W        = 4;
    localparam int DEF_OUT_W       = 3;
    localparam int DEF_RND_W       = 4;
    localparam int DEF_CORE_LAT    = 1;
    localparam int DEF_RND_TIMEOUT = 16;

    localparam int IN_COLD  = 0;
    localparam int IN_HOT   = 1;
    localparam int IN_MODE  = 2;
    localparam int IN_FAN   = 3;

    localparam int OUT_HEAT = 0;
    localparam int OUT_AC   = 1;
    localparam int OUT_FAN  = 2;

endpackage

// File: rtl/mask_share_codec.sv
// Plain-domain encode/decode wrapper around a two-share masked core.
// Masks the input from fresh RNG words and recombines registered shares.
module mask_share_codec
    import mask_codec_pkg::*;
#(
    parameter int IN_W        = DEF_IN_W,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int RND_W       = DEF_RND_W,
    parameter int CORE_LAT    = DEF_CORE_LAT,
    parameter int RND_TIMEOUT = DEF_RND_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   rnd_valid,
    output logic                   rnd_ready,
    input  logic [IN_W+RND_W-1:0]  rnd_data,
    output logic [IN_W-1:0]        sh0_out,
    output logic [IN_W-1:0]        sh1_out,
    output logic [RND_W-1:0]       gad_rnd,
    input  logic [OUT_W-1:0]       sh0_in,
    input  logic [OUT_W-1:0]       sh1_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   busy,
    output logic                   rnd_err
);

    localparam int WW = $clog2(RND_TIMEOUT + 1);
    localparam int SW = $clog2(CORE_LAT + 1);
    localparam logic [WW-1:0] TO_V   = WW'(RND_TIMEOUT);
    localparam logic [SW-1:0] LAT_M1 = SW'(CORE_LAT - 1);

    state_e           state_q, state_d;
    logic [IN_W-1:0]  plain_q, plain_d;
    logic [IN_W-1:0]  sh0_q, sh0_d;
    logic [IN_W-1:0]  sh1_q, sh1_d;
    logic [RND_W-1:0] gr_q, gr_d;
    logic [OUT_W-1:0] q0_q, q0_d;
    logic [OUT_W-1:0] q1_q, q1_d;
    logic [OUT_W-1:0] od_q, od_d;
    logic             ov_q, ov_d;
    logic             err_q, err_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [SW-1:0]    set_q, set_d;

    logic [IN_W-1:0]  rnd_m;
    logic [RND_W-1:0] rnd_r;

    assign rnd_m = rnd_data[IN_W-1:0];
    assign rnd_r = rnd_data[IN_W+RND_W-1:IN_W];

    assign in_ready  = (state_q == IDLE);
    assign rnd_ready = (state_q == RND);
    assign busy      = (state_q != IDLE);
    assign sh0_out   = sh0_q;
    assign sh1_out   = sh1_q;
    assign gad_rnd   = gr_q;
    assign out_data  = od_q;
    assign out_valid = ov_q;
    assign rnd_err   = err_q;

    // State and datapath registers; reset wipes every share and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            plain_q <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            gr_q    <= '0;
            q0_q    <= '0;
            q1_q    <= '0;
            od_q    <= '0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
            wait_q  <= '0;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            plain_q <= plain_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            gr_q    <= gr_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            od_q    <= od_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
            set_q   <= set_d;
        end
    end

    // Next-state and datapath updates for the encode/settle/decode sequence.
    always_comb begin
        state_d = state_q;
        plain_d = plain_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        gr_d    = gr_q;
        q0_d    = q0_q;
        q1_d    = q1_q;
        od_d    = od_q;
        ov_d    = ov_q;
        err_d   = err_q;
        wait_d  = wait_q;
        set_d   = set_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    plain_d = in_data;
                    wait_d  = '0;
                    state_d = RND;
                end
            end
            RND: begin
                if (rnd_valid) begin
                    sh0_d   = plain_q ^ rnd_m;
                    sh1_d   = rnd_m;
                    gr_d    = rnd_r;
                    plain_d = '0;
                    set_d   = LAT_M1;
                    state_d = SETTLE;
                end else begin
                    if (wait_q != TO_V) begin
                        wait_d = wait_q + 1'b1;
                    end
                    if (wait_d == TO_V) begin
                        err_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (set_q == '0) begin
                    q0_d    = sh0_in;
                    q1_d    = sh1_in;
                    state_d = UNMASK;
                end else begin
                    set_d = set_q - 1'b1;
                end
            end
            UNMASK: begin
                od_d    = q0_q ^ q1_q;
                ov_d    = 1'b1;
                sh0_d   = '0;
                sh1_d   = '0;
                gr_d    = '0;
                q0_d    = '0;
                q1_d    = '0;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    od_d    = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mask_share_codec.sv
// Randomised self-checking bench for mask_share_codec.
// A stand-in masked thermostat core closes the share loop.
module tb_mask_share_codec;

    localparam int CORE_LAT = 1;
    localparam int RTO      = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       rnd_valid = 1'b0;
    logic       rnd_ready;
    logic [7:0] rnd_data = '0;
    logic [3:0] sh0_out;
    logic [3:0] sh1_out;
    logic [3:0] gad_rnd;
    logic [2:0] sh0_in;
    logic [2:0] sh1_in;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_data;
    logic       busy;
    logic       rnd_err;

    int   n_cmp = 0;
    int   n_err = 0;
    logic err_m = 1'b0;
    logic use_core = 1'b1;
    logic [2:0] man0 = '0;
    logic [2:0] man1 = '0;

    mask_share_codec #(
        .IN_W(4), .OUT_W(3), .RND_W(4),
        .CORE_LAT(CORE_LAT), .RND_TIMEOUT(RTO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .rnd_data(rnd_data),
        .sh0_out(sh0_out), .sh1_out(sh1_out),
        .gad_rnd(gad_rnd),
        .sh0_in(sh0_in), .sh1_in(sh1_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy), .rnd_err(rnd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] thermo(input logic [3:0] x);
        logic heat, ac;
        heat = x[2] & x[0];
        ac   = ~x[2] & x[1];
        return {heat | ac | x[3], ac, heat};
    endfunction

    // Stand-in core: remasks its result with gadget bits.
    always_comb begin
        if (use_core) begin
            sh1_in = gad_rnd[2:0];
            sh0_in = thermo(sh0_out ^ sh1_out) ^ gad_rnd[2:0];
        end else begin
            sh0_in = man0;
            sh1_in = man1;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'($urandom);
        rnd_valid = 1'b1;
        rnd_data  = 8'($urandom);
        out_ready = 1'($urandom);
        tick();
        tick();
        chk("rst_sh0", sh0_out, 0);
        chk("rst_sh1", sh1_out, 0);
        chk("rst_gad", gad_rnd, 0);
        chk("rst_od", out_data, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_err", rnd_err, 0);
        chk("rst_irdy", in_ready, 1);
        chk("rst_rrdy", rnd_ready, 0);
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        err_m     = 1'b0;
        tick();
        chk("rel_busy", busy, 0);
        chk("rel_err", rnd_err, 0);
    endtask

    task automatic run_txn(input logic [3:0] x, input logic [3:0] m,
                           input logic [3:0] r, input int dly,
                           input int bp, input logic [2:0] want);
        int n;
        logic [2:0] hold;
        in_data  = x;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        chk("acc_rrdy", rnd_ready, 1);
        for (int i = 1; i <= dly; i++) begin
            tick();
            if (i >= RTO) err_m = 1'b1;
            chk("wait_err", rnd_err, err_m);
        end
        rnd_data  = {r, m};
        rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
        rnd_data  = 8'($urandom);
        chk("sh0", sh0_out, x ^ m);
        chk("sh1", sh1_out, m);
        chk("gad", gad_rnd, r);
        chk("rnd_done", rnd_ready, 0);
        n = 0;
        while (!out_valid && n < CORE_LAT + 8) begin
            tick();
            n++;
        end
        chk("lat", n, CORE_LAT + 1);
        chk("ov", out_valid, 1);
        chk("od", out_data, want);
        chk("clr_sh", {sh0_out, sh1_out, gad_rnd}, 0);
        hold = out_data;
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_od", out_data, hold);
            chk("bp_ov", out_valid, 1);
            chk("bp_irdy", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("done_ov", out_valid, 0);
        chk("done_od", out_data, 0);
        chk("done_irdy", in_ready, 1);
        chk("done_err", rnd_err, err_m);
    endtask

    initial begin
        logic [3:0] x, m, r;
        int d;
        do_reset();

        use_core = 1'b0;
        man0 = 3'b101;
        man1 = 3'b011;
        run_txn(4'b1010, 4'b0110, 4'b1001, 0, 0, 3'b110);
        use_core = 1'b1;

        for (int k = 0; k < 50; k++) begin
            m = (k == 0) ? 4'b0000 : 4'($urandom);
            r = 4'($urandom);
            run_txn(4'b0101, m, r, 0, 0, 3'b101);
            m = 4'($urandom);
            r = 4'($urandom);
            run_txn(4'b0010, m, r, 0, 0, 3'b110);
            m = 4'($urandom);
            r = 4'($urandom);
            run_txn(4'b0000, m, r, 0, 0, 3'b000);
        end

        for (int k = 0; k < 40; k++) begin
            x = 4'($urandom);
            m = 4'($urandom);
            r = 4'($urandom);
            d = $urandom_range(0, 3);
            run_txn(x, m, r, d, $urandom_range(0, 3), thermo(x));
        end

        x = 4'($urandom);
        run_txn(x, 4'b1011, 4'b0110, 20, 5, thermo(x));
        x = 4'($urandom);
        run_txn(x, 4'b0001, 4'b1110, 2, 0, thermo(x));

        in_data  = 4'b0011;
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        rnd_data  = {4'b1111, 4'b0101};
        rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
        chk("pre_sh0", sh0_out, 4'b0110);
        rst_n = 1'b0;
        #1;
        chk("ar_sh0", sh0_out, 0);
        chk("ar_sh1", sh1_out, 0);
        chk("ar_gad", gad_rnd, 0);
        chk("ar_irdy", in_ready, 1);
        chk("ar_err", rnd_err, 0);
        err_m = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ar_noov", out_valid, 0);
        end
        x = 4'($urandom);
        run_txn(x, 4'($urandom), 4'($urandom), 1, 1, thermo(x));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
